// File: rtl/dtree_feature_loader.sv
// Feature-frame loader for a combinational decision-tree classifier: collects
// N_FEAT bytes into a register vector, waits SETTLE cycles, then registers the class.
module dtree_feature_loader #(
    parameter int N_FEAT = 20,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [8*N_FEAT-1:0]   feat,
    input  logic [1:0]            cls_in,
    output logic                  m_valid,
    output logic [1:0]            m_class,
    input  logic                  m_ready,
    output logic                  frame_err,
    output logic [1:0]            dbg_state_o
);

    // Handshakes: a byte moves on a rising edge where s_valid && s_ready;
    // a result moves on a rising edge where m_valid && m_ready. Neither side
    // may withdraw valid before the transfer, and ready is ignored otherwise.

    localparam int          IW          = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_FEAT - 1);
    localparam logic [3:0]  SETTLE_INIT = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OUT    = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [8*N_FEAT-1:0] feat_q;
    logic                m_valid_q, m_valid_d;
    logic [1:0]          m_class_q, m_class_d;
    logic                frame_err_q, frame_err_d;
    logic                live_q;

    logic accept;
    logic at_end;
    logic frame_done;

    assign accept     = s_valid && s_ready;
    assign at_end     = (idx_q == LAST_IDX);
    assign frame_done = accept && s_last && at_end;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:   if (frame_done) state_d = ST_SETTLE;
            ST_SETTLE: if (cnt_q == 4'd0) state_d = ST_OUT;
            ST_OUT:    if (m_ready) state_d = ST_LOAD;
            default:   state_d = ST_LOAD;
        endcase
    end

    // Output logic; live_q keeps s_ready low until the first edge after reset
    always_comb begin
        s_ready     = live_q && (state_q == ST_LOAD);
        dbg_state_o = state_q;
    end

    always_comb begin
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        m_valid_d   = m_valid_q;
        m_class_d   = m_class_q;
        frame_err_d = accept && (s_last != at_end);

        if (accept) begin
            idx_d = (s_last || at_end) ? '0 : idx_q + 1'b1;
        end

        if (frame_done) begin
            cnt_d = SETTLE_INIT;
        end else if (state_q == ST_SETTLE && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end

        if (state_q == ST_SETTLE && cnt_q == 4'd0) begin
            m_valid_d = 1'b1;
            m_class_d = cls_in;
        end else if (state_q == ST_OUT && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            cnt_q       <= '0;
            m_valid_q   <= 1'b0;
            m_class_q   <= 2'b00;
            frame_err_q <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            m_valid_q   <= m_valid_d;
            m_class_q   <= m_class_d;
            frame_err_q <= frame_err_d;
            live_q      <= 1'b1;
        end
    end

    // Only the addressed slot is written; accept is already gated to LOAD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_q <= '0;
        end else begin
            for (int k = 0; k < N_FEAT; k++) begin
                if (accept && idx_q == IW'(k)) begin
                    feat_q[8*k +: 8] <= s_data;
                end
            end
        end
    end

    assign feat      = feat_q;
    assign m_valid   = m_valid_q;
    assign m_class   = m_class_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_dtree_feature_loader.sv
// Bench for dtree_feature_loader: stub tree classifier, frame-level reference
// model feeding an expected queue, and a monitor that pops on each result handshake.
module tb_dtree_feature_loader;

    localparam int N   = 20;
    localparam int ST  = 2;
    localparam int FW  = 8 * N;
    typedef logic [FW+1:0] wide_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [FW-1:0] feat;
    logic [1:0]    cls_in;
    logic          m_valid;
    logic [1:0]    m_class;
    logic          m_ready = 1'b0;
    logic          frame_err;
    logic [1:0]    dbg_state;

    logic          cls_override = 1'b0;
    logic [1:0]    cls_force = 2'b00;
    int            mr_mode = 0;
    int            tests = 0;
    int            fails = 0;
    int            err_exp = 0;
    int            err_seen = 0;

    wide_t         exp_q[$];
    logic [7:0]    mbuf[$];

    dtree_feature_loader #(.N_FEAT(N), .SETTLE(ST)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready), .feat(feat), .cls_in(cls_in),
        .m_valid(m_valid), .m_class(m_class), .m_ready(m_ready),
        .frame_err(frame_err), .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Stub decision tree over features X0, X3, X5, X19
    function automatic logic [1:0] tree(input logic [FW-1:0] v);
        if (v[7:0] < 8'h80) return (v[8*19 +: 8] > v[8*3 +: 8]) ? 2'd2 : 2'd1;
        else                return v[8*5] ? 2'd3 : 2'd0;
    endfunction

    assign cls_in = cls_override ? cls_force : tree(feat);

    function automatic void check(input string name, input wide_t got, input wide_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // ---------------- reference model (frame rules on a byte queue) ----------------
    function automatic void model_byte(input logic [7:0] d, input logic l);
        logic [FW-1:0] v;
        mbuf.push_back(d);
        if (l) begin
            if (mbuf.size() == N) begin
                for (int i = 0; i < N; i++) v[8*i +: 8] = mbuf[i];
                exp_q.push_back({tree(v), v});
            end else begin
                err_exp++;
            end
            mbuf.delete();
        end else if (mbuf.size() == N) begin
            err_exp++;
            mbuf.delete();
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] d, input logic l);
        int t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 200) begin
            tests++;
            fails++;
            $display("FAIL s_ready_timeout: got 0 expected 1 at %0t", $time);
        end else begin
            @(posedge clk);
            #1;
            model_byte(d, l);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!m_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 50) begin
            tests++;
            fails++;
            $display("FAIL m_valid_timeout: got 0 expected 1 at %0t", $time);
        end
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        #1;
        check("rst_feat", wide_t'(feat), '0);
        check("rst_m_valid", wide_t'(m_valid), '0);
        check("rst_m_class", wide_t'(m_class), '0);
        check("rst_s_ready", wide_t'(s_ready), '0);
        check("rst_frame_err", wide_t'(frame_err), '0);
        exp_q.delete();
        mbuf.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_rel_s_ready_low", wide_t'(s_ready), '0);
        @(posedge clk);
        #1;
        check("rst_rel_s_ready_high", wide_t'(s_ready), wide_t'(1));
    endtask

    task automatic send_frame_rand();
        for (int i = 0; i < N; i++) send_byte(8'($urandom), i == N - 1);
    endtask

    always @(posedge clk) begin
        #1;
        if (mr_mode == 2) m_ready = ($urandom_range(0, 3) != 0);
    end

    // ---------------- monitor / scoreboard ----------------
    logic       prev_stall = 1'b0;
    logic [1:0] prev_cls = 2'b00;
    wide_t      e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (frame_err) err_seen++;
            if (prev_stall) begin
                check("hold_valid", wide_t'(m_valid), wide_t'(1));
                check("hold_class", wide_t'(m_class), wide_t'(prev_cls));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got class %0d expected none at %0t", m_class, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("class_feat", {m_class, feat}, e);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_cls   = m_class;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int t;
        int e0;
        logic [FW-1:0] snap;

        #1;
        check("init_m_valid", wide_t'(m_valid), '0);
        check("init_feat", wide_t'(feat), '0);
        check("init_s_ready", wide_t'(s_ready), '0);
        check("init_frame_err", wide_t'(frame_err), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("init_s_ready_rise", wide_t'(s_ready), wide_t'(1));

        // Nominal frame 0x00..0x13
        for (int i = 0; i < N; i++) send_byte(8'(i), i == N - 1);
        wait_valid(lat);
        check("latency", wide_t'(lat), wide_t'(ST));
        check("nom_class", wide_t'(m_class), wide_t'(2));
        check("nom_feat_lo", wide_t'(feat[7:0]), '0);
        check("nom_feat_hi", wide_t'(feat[FW-1 -: 8]), wide_t'(8'h13));
        check("nom_s_ready", wide_t'(s_ready), '0);

        // Backpressure with toggling classifier and an ignored s_valid
        snap = feat;
        cls_override = 1'b1;
        cls_force = 2'b01;
        s_valid = 1'b1;
        s_data = 8'hFF;
        repeat (10) begin
            cls_force = ~cls_force;
            @(posedge clk);
            #1;
            check("bp_valid", wide_t'(m_valid), wide_t'(1));
            check("bp_class", wide_t'(m_class), wide_t'(2));
            check("bp_s_ready", wide_t'(s_ready), '0);
        end
        check("bp_feat_stable", wide_t'(feat), wide_t'(snap));
        s_valid = 1'b0;
        cls_override = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", wide_t'(m_valid), '0);
        check("bp_release_s_ready", wide_t'(s_ready), wide_t'(1));
        m_ready = 1'b0;

        // Short frame: last on byte 5
        e0 = err_seen;
        for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i), i == 4);
        check("short_err_pulse", wide_t'(frame_err), wide_t'(1));
        @(posedge clk);
        #1;
        check("short_err_clear", wide_t'(frame_err), '0);
        check("short_stay_load", wide_t'(s_ready), wide_t'(1));
        check("short_no_valid", wide_t'(m_valid), '0);
        m_ready = 1'b1;
        send_frame_rand();
        wait_valid(lat);
        check("short_err_once", wide_t'(err_seen - e0), wide_t'(1));
        @(posedge clk);
        #1;
        m_ready = 1'b0;

        // Long frame: 20 bytes without last, 21st lands in slot 0
        for (int i = 0; i < N; i++) send_byte(8'hA0 + 8'(i), 1'b0);
        check("long_err_pulse", wide_t'(frame_err), wide_t'(1));
        send_byte(8'h5A, 1'b0);
        check("long_slot0", wide_t'(feat[7:0]), wide_t'(8'h5A));
        check("long_err_clear", wide_t'(frame_err), '0);
        for (int i = 1; i < N; i++) send_byte(8'($urandom), i == N - 1);
        m_ready = 1'b1;
        wait_valid(lat);
        @(posedge clk);
        #1;
        m_ready = 1'b0;

        // Reset during the 10th byte
        for (int i = 0; i < 9; i++) send_byte(8'($urandom), 1'b0);
        s_valid = 1'b1;
        s_data = 8'h77;
        #2;
        apply_reset();
        m_ready = 1'b1;
        send_frame_rand();
        wait_valid(lat);
        @(posedge clk);
        #1;

        // Reset while a result is pending in OUT
        m_ready = 1'b0;
        send_frame_rand();
        wait_valid(lat);
        apply_reset();
        m_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("no_spurious_valid", wide_t'(m_valid), '0);
        m_ready = 1'b0;

        // Random frames with gaps and m_ready throttling
        mr_mode = 2;
        for (int f = 0; f < 1000; f++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 19);
            len = (kind == 0) ? $urandom_range(1, N - 1) : N;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
                send_byte(8'($urandom), (kind != 1) && (i == len - 1));
            end
        end

        mr_mode = 0;
        m_ready = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", wide_t'(exp_q.size()), '0);
        check("err_count", wide_t'(err_seen), wide_t'(err_exp));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
